safe_ctrl: RTL and testbench
============================

// Module: safe_ctrl
// PURPOSE
//  Safe-lock sequencer driven by the button press classifier: one-cycle 'save' (short press)
//  and 'lock' (long press) pulses. Stores a user code from switches, locks the safe, checks
//  entered codes, shows a 1 s error indication and enforces a timed lockout after repeated
//  wrong codes. Sits between the press classifier and the LED/solenoid outputs.
// PARAMETERS
//  SECONDS      50_000_000  clock cycles per second (tick period)
//  CODE_W       4           code width, bits (switch inputs)
//  MAX_FAILS    3           consecutive wrong codes that trigger lockout (>=1)
//  LOCKOUT_SEC  10          lockout duration in seconds (>=1)
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     reset, asynchronous, active-low
//  save       in   1                     short-press pulse, 1 cycle
//  lock       in   1                     long-press pulse, 1 cycle
//  code_in    in   CODE_W                switch code, sampled on the accepted pulse
//  unlocked   out  1                     safe open (solenoid released)
//  locked     out  1                     safe closed, accepting code entry
//  err        out  1                     wrong-code indication
//  lockout    out  1                     lockout active, all input ignored
//  fail_cnt   out  $clog2(MAX_FAILS+1)   consecutive wrong codes so far
// BEHAVIOUR
//  - States: OPEN, LOCKED, ERROR, LOCKOUT. Outputs are Moore decodes of the state register:
//    unlocked=OPEN, locked=LOCKED, err=ERROR, lockout=LOCKOUT; exactly one is high.
//  - Reset (rst=0, any time, mid-operation included): state OPEN, stored code 0,
//    code_valid 0, fail_cnt 0, timers 0. So unlocked=1, all other outputs 0.
//  - save and lock high in the same cycle: both ignored in every state.
//  - OPEN: save -> code_reg<=code_in, code_valid<=1, stay OPEN.
//    lock with code_valid=1 -> LOCKED next cycle. lock with code_valid=0 -> ignored.
//  - LOCKED: save with code_in==code_reg -> OPEN, fail_cnt<=0.
//    save with mismatch -> fail_cnt<=fail_cnt+1, ERROR. lock -> ignored.
//  - ERROR: holds exactly SECONDS cycles, inputs ignored. Then LOCKOUT if
//    fail_cnt==MAX_FAILS, else LOCKED.
//  - LOCKOUT: holds exactly LOCKOUT_SEC*SECONDS cycles, inputs ignored. Then LOCKED and
//    fail_cnt<=0. Stored code is kept.
//  - Latency: an accepted pulse in cycle N is visible on the outputs in cycle N+1.
//  - Timer: cycle counter 0..SECONDS-1 with terminal tick, plus a second counter
//    0..LOCKOUT_SEC-1. Both clear on every state change and count only in ERROR and
//    LOCKOUT. No wrap-around while counting, because the state exits on the terminal count.
//  - fail_cnt saturates at MAX_FAILS. It is never incremented outside LOCKED.
//  - All registers reset asynchronously. Next-state logic is combinational, with defaults
//    that hold the current state.
// STRUCTURE
//  - Shared package safe_pkg: state encoding (OPEN=0, LOCKED=1, ERROR=2, LOCKOUT=3) and the
//    2-bit state width. The safe-wide SECONDS default also lives there.
//  - One sub-module, sec_timer (clk, rst, clr, en -> tick, sec_cnt): the cycle and second
//    counters. FSM and code register stay in safe_ctrl.
//  - Top level instantiates the press classifier followed by safe_ctrl.
// TESTING (SECONDS=10, MAX_FAILS=3, LOCKOUT_SEC=2)
//  1. Reset, then lock pulse -> stays OPEN (no code stored).
//     save with code 4'hA, then lock -> locked=1 one cycle after the lock pulse.
//  2. In LOCKED, save with code_in=4'hA -> unlocked=1 next cycle, fail_cnt=0.
//  3. In LOCKED, save with 4'h3 -> err=1 for exactly 10 cycles, fail_cnt=1, then locked=1.
//     A save pulse during ERROR has no effect.
//  4. Three wrong codes -> after the 3rd ERROR, lockout=1 for exactly 20 cycles and a
//     correct code is ignored; then locked=1, fail_cnt=0; code 4'hA then opens the safe.
//  5. rst low mid-LOCKOUT -> outputs immediately unlocked=1, fail_cnt=0.
//     A subsequent lock pulse is ignored (code_valid cleared).
//  6. save and lock asserted in the same cycle, in both OPEN and LOCKED -> no state,
//     code or fail_cnt change.

Source files
------------

// File: rtl/safe_pkg.sv
// Shared definitions for the safe-lock sequencer.
package safe_pkg;

   localparam int unsigned STATE_W     = 2;
   localparam int unsigned SECONDS_DEF = 50_000_000;

   typedef enum logic [STATE_W-1:0] {
      OPEN    = 2'd0,
      LOCKED  = 2'd1,
      ERROR   = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

endpackage

// File: rtl/safe_sec_timer.sv
// Cycle counter with a one-second terminal tick, plus a seconds counter.
// Both clear on clr and only advance while en is high.
module sec_timer #(
   parameter int unsigned SECONDS     = safe_pkg::SECONDS_DEF,
   parameter int unsigned LOCKOUT_SEC = 10,
   localparam int unsigned CYC_W = (SECONDS > 1) ? $clog2(SECONDS) : 1,
   localparam int unsigned SEC_W = (LOCKOUT_SEC > 1) ? $clog2(LOCKOUT_SEC) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic             tick,
   output logic [SEC_W-1:0] sec_cnt
);

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SECONDS - 1);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(LOCKOUT_SEC - 1);

   logic [CYC_W-1:0] cyc_cnt;

   // Terminal tick on the last cycle of each second while enabled.
   always_comb begin
      tick = en && (cyc_cnt == CYC_LAST);
   end

   // Cycle and second counters; the seconds count stops at its last value
   // because the owning state exits on that terminal count anyway.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_cnt <= '0;
         sec_cnt <= '0;
      end else if (clr) begin
         cyc_cnt <= '0;
         sec_cnt <= '0;
      end else if (en) begin
         if (tick) begin
            cyc_cnt <= '0;
            if (sec_cnt != SEC_LAST) sec_cnt <= sec_cnt + 1'b1;
         end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/safe_ctrl.sv
// Safe-lock sequencer: stores a code, locks, checks entered codes, shows a
// one-second error indication and enforces a timed lockout after repeated
// wrong codes. Outputs are Moore decodes of the state register.
module safe_ctrl
   import safe_pkg::*;
#(
   parameter int unsigned SECONDS     = SECONDS_DEF,
   parameter int unsigned CODE_W      = 4,
   parameter int unsigned MAX_FAILS   = 3,
   parameter int unsigned LOCKOUT_SEC = 10,
   localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1),
   localparam int unsigned SEC_W  = (LOCKOUT_SEC > 1) ? $clog2(LOCKOUT_SEC) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              save,
   input  logic              lock,
   input  logic [CODE_W-1:0] code_in,
   output logic              unlocked,
   output logic              locked,
   output logic              err,
   output logic              lockout,
   output logic [FAIL_W-1:0] fail_cnt
);

   localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
   localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(LOCKOUT_SEC - 1);

   state_t              state, state_next;
   logic [CODE_W-1:0]   code_reg, code_next;
   logic                code_valid, valid_next;
   logic [FAIL_W-1:0]   fail_next;
   logic                save_ok, lock_ok;
   logic                tmr_clr, tmr_en, tick;
   logic [SEC_W-1:0]    sec_cnt;

   sec_timer #(
      .SECONDS     (SECONDS),
      .LOCKOUT_SEC (LOCKOUT_SEC)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .tick    (tick),
      .sec_cnt (sec_cnt)
   );

   // Registers for state, stored code and consecutive-failure count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= OPEN;
         code_reg   <= '0;
         code_valid <= 1'b0;
         fail_cnt   <= '0;
      end else begin
         state      <= state_next;
         code_reg   <= code_next;
         code_valid <= valid_next;
         fail_cnt   <= fail_next;
      end
   end

   // Next-state, code and failure-count logic; defaults hold everything.
   always_comb begin
      state_next = state;
      code_next  = code_reg;
      valid_next = code_valid;
      fail_next  = fail_cnt;
      save_ok    = save && !lock;
      lock_ok    = lock && !save;
      unique case (state)
         OPEN: begin
            if (save_ok) begin
               code_next  = code_in;
               valid_next = 1'b1;
            end else if (lock_ok && code_valid) begin
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (save_ok) begin
               if (code_in == code_reg) begin
                  state_next = OPEN;
                  fail_next  = '0;
               end else begin
                  state_next = ERROR;
                  if (fail_cnt != FAIL_MAX) fail_next = fail_cnt + 1'b1;
               end
            end
         end
         ERROR: begin
            if (tick) state_next = (fail_cnt == FAIL_MAX) ? LOCKOUT : LOCKED;
         end
         LOCKOUT: begin
            if (tick && (sec_cnt == SEC_LAST)) begin
               state_next = LOCKED;
               fail_next  = '0;
            end
         end
         default: state_next = OPEN;
      endcase
   end

   // Timer runs only in the timed states and restarts on every state change.
   always_comb begin
      tmr_en  = (state == ERROR) || (state == LOCKOUT);
      tmr_clr = (state_next != state);
   end

   // Moore output decode: exactly one indicator is high.
   always_comb begin
      unlocked = (state == OPEN);
      locked   = (state == LOCKED);
      err      = (state == ERROR);
      lockout  = (state == LOCKOUT);
   end

endmodule

// File: tb/tb_safe_ctrl.sv
// Directed bench for safe_ctrl with short timing (10-cycle second, 2 s lockout).
module tb_safe_ctrl;

   localparam int unsigned SEC = 10;
   localparam int unsigned MF  = 3;
   localparam int unsigned LS  = 2;

   // Indicator vector {lockout, err, locked, unlocked}
   localparam int S_O = 1;
   localparam int S_L = 2;
   localparam int S_E = 4;
   localparam int S_X = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       save = 1'b0;
   logic       lock = 1'b0;
   logic [3:0] code_in = '0;
   logic       unlocked, locked, err, lockout;
   logic [1:0] fail_cnt;

   int tests = 0;
   int fails = 0;

   safe_ctrl #(
      .SECONDS     (SEC),
      .CODE_W      (4),
      .MAX_FAILS   (MF),
      .LOCKOUT_SEC (LS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .save     (save),
      .lock     (lock),
      .code_in  (code_in),
      .unlocked (unlocked),
      .locked   (locked),
      .err      (err),
      .lockout  (lockout),
      .fail_cnt (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int st();
      return int'({lockout, err, locked, unlocked});
   endfunction

   // Drive one cycle of inputs from a falling edge; returns at the next falling
   // edge, where the result of that cycle is already on the outputs.
   task automatic press(input logic s, input logic l, input logic [3:0] c);
      @(negedge clk);
      save = s; lock = l; code_in = c;
      @(negedge clk);
      save = 1'b0; lock = 1'b0;
   endtask

   // Wrong code from LOCKED: ERROR for exactly SEC cycles, then the next state.
   task automatic wrong_code(input string tag, input int exp_fail, input int exp_after);
      press(1'b1, 1'b0, 4'h3);
      check({tag, "_err0"}, st(), S_E);
      check({tag, "_fcnt"}, int'(fail_cnt), exp_fail);
      for (int i = 1; i < int'(SEC); i++) begin
         @(negedge clk);
         check({tag, "_errhold"}, st(), S_E);
      end
      @(negedge clk);
      check({tag, "_after"}, st(), exp_after);
   endtask

   initial begin
      // Reset state
      #1;
      check("rst_state", st(), S_O);
      check("rst_fcnt", int'(fail_cnt), 0);
      @(negedge clk);
      rst = 1'b1;

      // 1. lock without stored code ignored; store A then lock
      press(1'b0, 1'b1, 4'h0);
      check("lock_nocode", st(), S_O);
      press(1'b1, 1'b0, 4'hA);
      check("save_open", st(), S_O);
      press(1'b0, 1'b1, 4'h0);
      check("lock_ok", st(), S_L);

      // 2. correct code opens
      press(1'b1, 1'b0, 4'hA);
      check("open_ok", st(), S_O);
      check("open_fcnt", int'(fail_cnt), 0);
      press(1'b0, 1'b1, 4'h0);
      check("relock", st(), S_L);

      // 3. wrong code: ERROR for 10 cycles, save ignored inside ERROR
      press(1'b1, 1'b0, 4'h3);
      check("w1_err0", st(), S_E);
      check("w1_fcnt", int'(fail_cnt), 1);
      for (int i = 1; i < int'(SEC); i++) begin
         @(negedge clk);
         check("w1_errhold", st(), S_E);
         save = (i == 4);
         code_in = 4'hA;
      end
      @(negedge clk);
      check("w1_after", st(), S_L);
      check("w1_fcnt_after", int'(fail_cnt), 1);

      // 4. two more wrong codes -> LOCKOUT for 20 cycles, correct code ignored
      wrong_code("w2", 2, S_L);
      wrong_code("w3", 3, S_X);
      check("lo_fcnt", int'(fail_cnt), 3);
      for (int i = 1; i < int'(SEC * LS); i++) begin
         @(negedge clk);
         check("lo_hold", st(), S_X);
         save = (i == 7);
         code_in = 4'hA;
      end
      @(negedge clk);
      check("lo_after", st(), S_L);
      check("lo_fcnt_clr", int'(fail_cnt), 0);
      press(1'b1, 1'b0, 4'hA);
      check("lo_reopen", st(), S_O);

      // 6. save and lock together ignored in OPEN and LOCKED
      press(1'b1, 1'b1, 4'h5);
      check("both_open", st(), S_O);
      press(1'b0, 1'b1, 4'h0);
      check("both_relock", st(), S_L);
      press(1'b1, 1'b1, 4'h5);
      check("both_locked", st(), S_L);
      check("both_fcnt", int'(fail_cnt), 0);
      press(1'b1, 1'b0, 4'hA);
      check("both_code_kept", st(), S_O);

      // 5. reset in the middle of LOCKOUT
      press(1'b0, 1'b1, 4'h0);
      check("r_lock", st(), S_L);
      wrong_code("r1", 1, S_L);
      wrong_code("r2", 2, S_L);
      wrong_code("r3", 3, S_X);
      repeat (5) @(negedge clk);
      check("r_in_lockout", st(), S_X);
      rst = 1'b0;
      #1;
      check("r_async_state", st(), S_O);
      check("r_async_fcnt", int'(fail_cnt), 0);
      @(negedge clk);
      rst = 1'b1;
      press(1'b0, 1'b1, 4'h0);
      check("r_lock_ignored", st(), S_O);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
